// File: rtl/vliw_regfile_sb.sv
// Multi-port register file with writeback bypass, write-collision detection and a
// per-register latency scoreboard that flags RAW and WAW hazards to the issue stage.
module vliw_regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NUM_WR   = 6,
    parameter int unsigned NUM_RD   = 12,
    parameter int unsigned LAT_W    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    input  logic [NUM_RD-1:0]        rd_chk_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic [NUM_WR-1:0]        iss_valid_i,
    input  logic [NUM_WR*AW-1:0]     iss_dst_i,
    input  logic [NUM_WR*LAT_W-1:0]  iss_lat_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic [NUM_REGS-1:0]      busy_vec_o,
    output logic                     raw_hazard_o,
    output logic                     waw_hazard_o,
    output logic                     wr_conflict_o
);

    logic [DATA_W-1:0] rf_q  [NUM_REGS];
    logic [LAT_W-1:0]  cnt_q [NUM_REGS];
    logic [LAT_W-1:0]  cnt_d [NUM_REGS];
    logic              wr_conflict_q, wr_conflict_d;

    // Per-register winning write (highest port index) for this edge
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   wr_val [NUM_REGS];

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Write decode: later ports override earlier ones; a second hit on a register is a collision
    always_comb begin
        wr_hit        = '0;
        wr_conflict_d = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_val[r] = '0;
        end
        // R0 is skipped, so writes to it never land and never count as collisions
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == AW'(r))) begin
                    if (wr_hit[r]) begin
                        wr_conflict_d = 1'b1;
                    end
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register array, scoreboard counters and collision flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    rf_q[r] <= wr_val[r];
                end
                cnt_q[r] <= cnt_d[r];
            end
            cnt_q[0]      <= '0;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Read ports with same-cycle bypass; R0 and out-of-range addresses read zero
    always_comb begin
        logic [AW-1:0] a;
        a         = '0;
        rd_data_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a = rd_addr_i[i*AW +: AW];
            if ((a != '0) && in_range(a)) begin
                if (!rst_i && wr_hit[a]) begin
                    rd_data_o[i*DATA_W +: DATA_W] = wr_val[a];
                end else begin
                    rd_data_o[i*DATA_W +: DATA_W] = rf_q[a];
                end
            end
        end
    end

    // Scoreboard next state: saturating decrement, raised to the longest new issue latency
    always_comb begin
        logic [LAT_W-1:0] lat_max;
        logic [LAT_W-1:0] lat_k;
        logic [LAT_W-1:0] dec;
        lat_max = '0;
        lat_k   = '0;
        dec     = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            lat_max = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                lat_k = iss_lat_i[k*LAT_W +: LAT_W];
                if ((r != 0) && iss_valid_i[k] && (iss_dst_i[k*AW +: AW] == AW'(r)) &&
                    (lat_k > lat_max)) begin
                    lat_max = lat_k;
                end
            end
            dec      = (cnt_q[r] == '0) ? '0 : cnt_q[r] - LAT_W'(1);
            cnt_d[r] = (dec > lat_max) ? dec : lat_max;
        end
    end

    // Busy vector and RAW check against the current (pre-issue) counters
    always_comb begin
        logic [AW-1:0] a;
        a            = '0;
        raw_hazard_o = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec_o[r] = (cnt_q[r] != '0);
        end
        for (int i = 0; i < NUM_RD; i++) begin
            a = rd_addr_i[i*AW +: AW];
            if (rd_chk_i[i] && in_range(a) && (cnt_q[a] != '0)) begin
                raw_hazard_o = 1'b1;
            end
        end
    end

    // WAW: a new write would not outlive the pending one, or two slots target the same register
    always_comb begin
        logic [AW-1:0]    dst_k;
        logic [LAT_W-1:0] lat_k;
        logic [LAT_W-1:0] cur;
        dst_k        = '0;
        lat_k        = '0;
        cur          = '0;
        waw_hazard_o = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            dst_k = iss_dst_i[k*AW +: AW];
            lat_k = iss_lat_i[k*LAT_W +: LAT_W];
            cur   = in_range(dst_k) ? cnt_q[dst_k] : '0;
            if (iss_valid_i[k] && (lat_k != '0) && (lat_k <= cur)) begin
                waw_hazard_o = 1'b1;
            end
            for (int j = k + 1; j < NUM_WR; j++) begin
                if (iss_valid_i[k] && iss_valid_i[j] && (dst_k != '0) &&
                    (iss_dst_i[j*AW +: AW] == dst_k)) begin
                    waw_hazard_o = 1'b1;
                end
            end
        end
    end

    assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_vliw_regfile_sb.sv
// Directed bench for vliw_regfile_sb: table of single-write/read vectors plus
// hand-written sequences for collisions, reset, RAW timing and WAW detection.
module tb_vliw_regfile_sb;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
    localparam int NUM_WR   = 6;
    localparam int NUM_RD   = 12;
    localparam int LAT_W    = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD-1:0]        rd_chk;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        iss_valid;
    logic [NUM_WR*AW-1:0]     iss_dst;
    logic [NUM_WR*LAT_W-1:0]  iss_lat;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_REGS-1:0]      busy_vec;
    logic                     raw_hazard;
    logic                     waw_hazard;
    logic                     wr_conflict;

    int checks = 0;
    int errors = 0;
    int raw_cycles;

    vliw_regfile_sb #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .AW      (AW),
        .NUM_WR  (NUM_WR),
        .NUM_RD  (NUM_RD),
        .LAT_W   (LAT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_addr_i    (rd_addr),
        .rd_chk_i     (rd_chk),
        .rd_data_o    (rd_data),
        .iss_valid_i  (iss_valid),
        .iss_dst_i    (iss_dst),
        .iss_lat_i    (iss_lat),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .busy_vec_o   (busy_vec),
        .raw_hazard_o (raw_hazard),
        .waw_hazard_o (waw_hazard),
        .wr_conflict_o(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  raddr;
        logic [31:0] exp_byp;
        logic [31:0] exp_stored;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d);
        wr_en[k]                  = 1'b1;
        wr_addr[k*AW +: AW]       = a;
        wr_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_iss(input int k, input logic [4:0] d, input logic [3:0] l);
        iss_valid[k]              = 1'b1;
        iss_dst[k*AW +: AW]       = d;
        iss_lat[k*LAT_W +: LAT_W] = l;
    endtask

    task automatic clear_ctl();
        wr_en     = '0;
        iss_valid = '0;
    endtask

    // Probe WAW combinationally for a single slot without letting an edge pass
    task automatic probe_waw(input string name, input logic [4:0] d, input logic [3:0] l,
                             input logic exp);
        iss_valid = '0;
        set_iss(0, d, l);
        #1;
        chk(name, 64'(waw_hazard), 64'(exp));
        iss_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //         port en  addr  data          raddr byp           stored
        vecs[0] = '{1, 1'b0, 12, 32'h0000_0077, 12, 32'h0,         32'h0};
        vecs[1] = '{2, 1'b1, 7,  32'h0000_1234, 7,  32'h0000_1234, 32'h0000_1234};
        vecs[2] = '{0, 1'b1, 0,  32'h0000_FFFF, 0,  32'h0,         32'h0};
        vecs[3] = '{5, 1'b1, 31, 32'hCAFE_F00D, 31, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[4] = '{3, 1'b1, 7,  32'h0000_0000, 7,  32'h0,         32'h0};
        vecs[5] = '{1, 1'b1, 12, 32'h0000_0077, 12, 32'h0000_0077, 32'h0000_0077};
        vecs[6] = '{4, 1'b1, 13, 32'h0000_0099, 12, 32'h0000_0077, 32'h0000_0077};

        rst       = 1'b1;
        rd_addr   = '0;
        rd_chk    = '1;
        iss_valid = '0;
        iss_dst   = '0;
        iss_lat   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        #12;
        chk("reset_busy", 64'(busy_vec), 64'h0);
        chk("reset_conflict", 64'(wr_conflict), 64'h0);
        chk("reset_raw", 64'(raw_hazard), 64'h0);
        chk("reset_waw", 64'(waw_hazard), 64'h0);
        chk("reset_rd0", 64'(rd_data[31:0]), 64'h0);
        @(negedge clk);
        rst    = 1'b0;
        rd_chk = '0;

        // Table: one write on the listed port, read port 0 before and after the edge
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_ctl();
            if (vecs[i].en) set_wr(vecs[i].port, vecs[i].addr, vecs[i].data);
            rd_addr[0 +: AW] = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_bypass", i), 64'(rd_data[31:0]), 64'(vecs[i].exp_byp));
            @(posedge clk);
            #1;
            wr_en = '0;
            #1;
            chk($sformatf("vec%0d_stored", i), 64'(rd_data[31:0]), 64'(vecs[i].exp_stored));
        end

        // Collision: ports 1 and 4 on R9, port 4 wins, one-cycle conflict pulse
        @(negedge clk);
        clear_ctl();
        set_wr(1, 9, 32'h0000_AAAA);
        set_wr(4, 9, 32'h0000_5555);
        rd_addr[0 +: AW] = 9;
        #1;
        chk("coll_bypass", 64'(rd_data[31:0]), 64'h5555);
        chk("coll_conflict_pre", 64'(wr_conflict), 64'h0);
        @(posedge clk);
        #1;
        wr_en = '0;
        #1;
        chk("coll_stored", 64'(rd_data[31:0]), 64'h5555);
        chk("coll_conflict_pulse", 64'(wr_conflict), 64'h1);
        @(posedge clk);
        #1;
        chk("coll_conflict_clear", 64'(wr_conflict), 64'h0);

        // R0 collision is not a conflict
        @(negedge clk);
        set_wr(0, 0, 32'h0000_FFFF);
        set_wr(1, 0, 32'h0000_0001);
        rd_addr[0 +: AW] = 0;
        @(posedge clk);
        #1;
        wr_en = '0;
        #1;
        chk("r0_conflict", 64'(wr_conflict), 64'h0);
        chk("r0_read", 64'(rd_data[31:0]), 64'h0);

        // Reset mid-cycle discards data, pending writes and the conflict flag
        @(negedge clk);
        clear_ctl();
        set_wr(0, 5, 32'hDEAD_BEEF);
        set_wr(1, 9, 32'h1);
        set_wr(2, 9, 32'h2);
        set_iss(0, 5, 5);
        rd_addr[0 +: AW]  = 5;
        rd_addr[AW +: AW] = 9;
        @(posedge clk);
        #1;
        clear_ctl();
        #1;
        chk("pre_rst_r5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("pre_rst_conflict", 64'(wr_conflict), 64'h1);
        chk("pre_rst_busy5", 64'(busy_vec[5]), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_r5", 64'(rd_data[31:0]), 64'h0);
        chk("rst_r9", 64'(rd_data[2*DATA_W-1:DATA_W]), 64'h0);
        chk("rst_busy", 64'(busy_vec), 64'h0);
        chk("rst_conflict", 64'(wr_conflict), 64'h0);
        // Writes and issues while in reset are ignored
        set_wr(0, 5, 32'h1);
        set_iss(0, 5, 7);
        @(posedge clk);
        #1;
        clear_ctl();
        #1;
        chk("in_rst_write_r5", 64'(rd_data[31:0]), 64'h0);
        chk("in_rst_busy", 64'(busy_vec), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        // Late writeback after reset lands but creates no scoreboard entry
        set_wr(3, 5, 32'h55);
        @(posedge clk);
        #1;
        clear_ctl();
        #1;
        chk("late_wb_r5", 64'(rd_data[31:0]), 64'h55);
        chk("late_wb_busy", 64'(busy_vec), 64'h0);

        // RAW: slot 1 issues R3 with latency 13; hazard holds for 13 cycles
        @(negedge clk);
        clear_ctl();
        rd_chk           = '0;
        rd_chk[0]        = 1'b1;
        rd_addr[0 +: AW] = 3;
        set_iss(1, 3, 13);
        #1;
        chk("raw_before_issue", 64'(raw_hazard), 64'h0);
        raw_cycles = 0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            clear_ctl();
            #1;
            chk($sformatf("raw_edge%0d", n), 64'(raw_hazard), 64'(n <= 13));
            chk($sformatf("busy3_edge%0d", n), 64'(busy_vec[3]), 64'(n <= 13));
            if (raw_hazard) raw_cycles++;
            if (n == 13) set_wr(0, 3, 32'h3333);
            if (n == 14) chk("raw_wb_r3", 64'(rd_data[31:0]), 64'h3333);
        end
        chk("raw_cycle_count", 64'(raw_cycles), 64'd13);
        rd_chk = '0;

        // WAW: R3 pending with cnt=10, then shorter and longer reissues
        @(negedge clk);
        clear_ctl();
        set_iss(2, 3, 10);
        #1;
        chk("waw_first_issue", 64'(waw_hazard), 64'h0);
        @(posedge clk);
        #1;
        probe_waw("waw_cnt10_lat10", 3, 10, 1'b1);
        probe_waw("waw_cnt10_lat11", 3, 11, 1'b0);
        set_iss(2, 3, 4);
        #1;
        chk("waw_lat4", 64'(waw_hazard), 64'h1);
        @(posedge clk);
        #1;
        clear_ctl();
        probe_waw("waw_cnt9_lat9", 3, 9, 1'b1);
        probe_waw("waw_cnt9_lat10", 3, 10, 1'b0);
        set_iss(2, 3, 12);
        #1;
        chk("waw_lat12", 64'(waw_hazard), 64'h0);
        @(posedge clk);
        #1;
        clear_ctl();
        probe_waw("waw_cnt12_lat12", 3, 12, 1'b1);
        probe_waw("waw_cnt12_lat13", 3, 13, 1'b0);

        // Same-cycle double issue to R6, then reset two cycles later
        @(negedge clk);
        clear_ctl();
        set_iss(0, 6, 4);
        set_iss(3, 6, 5);
        #1;
        chk("dual_issue_waw", 64'(waw_hazard), 64'h1);
        @(posedge clk);
        #1;
        clear_ctl();
        chk("dual_busy6", 64'(busy_vec[6]), 64'h1);
        probe_waw("dual_cnt5_lat5", 6, 5, 1'b1);
        probe_waw("dual_cnt5_lat6", 6, 6, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("dual_busy6_pre_rst", 64'(busy_vec[6]), 64'h1);
        rst = 1'b1;
        #1;
        chk("dual_rst_busy6", 64'(busy_vec[6]), 64'h0);
        chk("dual_rst_busy_all", 64'(busy_vec), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two issues to R0 are neither tracked nor a WAW pair
        set_iss(0, 0, 3);
        set_iss(1, 0, 3);
        #1;
        chk("r0_pair_waw", 64'(waw_hazard), 64'h0);
        @(posedge clk);
        #1;
        clear_ctl();
        chk("r0_issue_busy", 64'(busy_vec), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
